// File: rtl/aes_128_pkg.sv
// Shared constants and types for the AES-128 key schedule: round count,
// round constants, controller state encoding and the round-key word type.
package aes_128_pkg;

  localparam int NR = 10;
  localparam int NK = 4;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  // Indexed by round number; entry 0 and entries past the last round are unused.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] result
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign result = SBOX[value];

endmodule

// File: rtl/aes_128_key_expand.sv
// AES-128 key schedule: expands one cipher key into 11 round keys (one per
// cycle) and streams them out one per key_ready request.
module aes_128_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         kill,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         key_ready,
  output logic [127:0] key_round,
  output logic         key_valid,
  output logic         busy
);

  import aes_128_pkg::*;

  localparam logic [3:0] LAST_RND = 4'(NR);

  round_key_t  rk_r [0:NR];
  state_t      state_r;
  logic [3:0]  rnd_r;
  logic [3:0]  idx_r;
  logic [3:0]  src_s;
  logic [3:0]  dst_s;
  logic [3:0]  rd_s;
  round_key_t  prev_s;
  round_key_t  next_s;
  logic [31:0] rot_s;
  logic [31:0] sub_s;
  logic [31:0] t_s;
  logic [31:0] w0_s;
  logic [31:0] w1_s;
  logic [31:0] w2_s;
  logic [31:0] w3_s;

  // Register-file addresses, clamped so an idle counter never reads past the last slot.
  always_comb begin
    src_s = 4'd0;
    dst_s = 4'd0;
    rd_s  = 4'd0;
    if ((rnd_r >= 4'd1) && (rnd_r <= LAST_RND)) begin
      src_s = rnd_r - 4'd1;
      dst_s = rnd_r;
    end else begin
      src_s = 4'd0;
      dst_s = 4'd0;
    end
    if (idx_r <= LAST_RND) begin
      rd_s = idx_r;
    end else begin
      rd_s = 4'd0;
    end
  end

  assign prev_s = rk_r[src_s];
  assign rot_s  = rot_word(prev_s[31:0]);

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .value  (rot_s[8*b +: 8]),
      .result (sub_s[8*b +: 8])
    );
  end

  assign t_s = sub_s ^ {RCON[rnd_r], 24'h000000};

  // One round of the word recurrence: each new word chains off the previous new word.
  always_comb begin
    w0_s   = prev_s[127:96] ^ t_s;
    w1_s   = prev_s[95:64]  ^ w0_s;
    w2_s   = prev_s[63:32]  ^ w1_s;
    w3_s   = prev_s[31:0]   ^ w2_s;
    next_s = {w0_s, w1_s, w2_s, w3_s};
  end

  // Round-key storage; contents are only observable in READY, so no reset.
  always_ff @(posedge clk) begin
    if (key_load) begin
      rk_r[0] <= key_in;
    end else if (state_r == ST_EXPAND) begin
      rk_r[dst_s] <= next_s;
    end
  end

  // Controller: load restarts from any state and outranks key_ready.
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      state_r <= ST_IDLE;
      rnd_r   <= 4'd0;
      idx_r   <= 4'd0;
    end else if (key_load) begin
      state_r <= ST_EXPAND;
      rnd_r   <= 4'd1;
      idx_r   <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_EXPAND: begin
          if (rnd_r == LAST_RND) begin
            state_r <= ST_READY;
          end else begin
            rnd_r <= rnd_r + 4'd1;
          end
        end
        ST_READY: begin
          if (key_ready) begin
            idx_r <= (idx_r == LAST_RND) ? 4'd0 : idx_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rnd_r   <= 4'd0;
          idx_r   <= 4'd0;
        end
      endcase
    end
  end

  // Round-key read port; forced to zero whenever the schedule is not valid.
  always_comb begin
    if (state_r == ST_READY) begin
      key_round = rk_r[rd_s];
    end else begin
      key_round = 128'd0;
    end
  end

  assign busy      = (state_r == ST_EXPAND);
  assign key_valid = (state_r == ST_READY);

endmodule

// File: tb/tb_aes_128_key_expand.sv
// Self-checking bench for aes_128_key_expand: FIPS-197 word-level key schedule
// model with a GF(2^8)-derived S-box, checked every cycle plus directed vectors.
module tb_aes_128_key_expand;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         kill;
  logic [127:0] key_in;
  logic         key_load;
  logic         key_ready;
  logic [127:0] key_round;
  logic         key_valid;
  logic         busy;

  int passed = 0;
  int total  = 0;

  bit   [7:0]   sb [256];
  bit   [127:0] m_rk [11];
  bit           m_valid = 1'b0;
  bit           m_busy  = 1'b0;
  int           m_idx   = 0;
  int           m_cnt   = 0;
  logic [127:0] obs [11];
  int           n;

  always #5 clk = ~clk;

  aes_128_key_expand #(.NR(10)) dut (
    .clk       (clk),
    .kill      (kill),
    .key_in    (key_in),
    .key_load  (key_load),
    .key_ready (key_ready),
    .key_round (key_round),
    .key_valid (key_valid),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
    bit [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic bit [7:0] rotl(input bit [7:0] x, input int s);
    bit [7:0] r = x;
    for (int i = 0; i < s; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic bit [7:0] sbox_calc(input bit [7:0] b);
    bit [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (b != 8'h00 && gmul(b, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic bit [127:0] round_key(input bit [127:0] key, input int r);
    bit [31:0] w [44];
    bit [31:0] t;
    bit [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Reference behaviour: 11-edge latency after load, then an 11-entry wrapping stream.
  always @(posedge clk or posedge kill) begin
    if (kill) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_idx   <= 0;
      m_cnt   <= 0;
    end else if (key_load) begin
      for (int r = 0; r < 11; r++) m_rk[r] <= round_key(key_in, r);
      m_busy  <= 1'b1;
      m_valid <= 1'b0;
      m_cnt   <= 10;
      m_idx   <= 0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
      end
      m_cnt <= m_cnt - 1;
    end else if (m_valid && key_ready) begin
      m_idx <= (m_idx == 10) ? 0 : m_idx + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("valid", 128'(key_valid), 128'(m_valid));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("round", key_round, m_valid ? m_rk[m_idx] : 128'd0);
  end

  task automatic wait_valid(input int start, output int cnt);
    cnt = start;
    while (!key_valid && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic do_load(input logic [127:0] k, output int cnt);
    key_in = k; key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    wait_valid(1, cnt);
  endtask

  task automatic pulse_ready(input int gap);
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic stream();
    for (int i = 0; i < 11; i++) begin
      obs[i] = key_round;
      pulse_ready(2);
    end
  endtask

  initial begin
    kill = 1'b1; key_load = 1'b0; key_ready = 1'b0; key_in = 128'd0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    chk("model_sbox00", 128'(sb[0]), 128'h63);
    chk("model_sbox53", 128'(sb[8'h53]), 128'hed);
    chk("model_k1_rk1", round_key(K1, 1), K1_R1);
    chk("model_k1_rk10", round_key(K1, 10), K1_R10);
    chk("model_k2_rk10", round_key(K2, 10), K2_R10);

    repeat (2) @(posedge clk); #1;
    chk("reset_valid", 128'(key_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_round", key_round, 128'd0);
    kill = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 A.1 expansion and streaming
    do_load(K1, n);
    chk("latency_k1", 128'(n), 128'd11);
    chk("k1_rk0", key_round, K1);
    stream();
    chk("stream_rk0", obs[0], K1);
    chk("stream_rk1", obs[1], K1_R1);
    chk("stream_rk10", obs[10], K1_R10);
    chk("wrap_rk0", key_round, K1);

    // Back-to-back requests, then collision at idx 4
    key_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    key_ready = 1'b0;
    chk("b2b_rk3", key_round, round_key(K1, 3));
    pulse_ready(1);
    chk("pre_collide_rk4", key_round, round_key(K1, 4));
    key_in = K1; key_load = 1'b1; key_ready = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0; key_ready = 1'b0;
    wait_valid(1, n);
    chk("latency_collide", 128'(n), 128'd11);
    chk("collide_idx0", key_round, K1);

    // Requests while busy are ignored
    key_in = K2; key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key_ready = 1'b1;
      @(posedge clk); #1;
      key_ready = 1'b0;
      chk("ignored_round", key_round, 128'd0);
    end
    wait_valid(4, n);
    chk("latency_ignored", 128'(n), 128'd11);
    chk("ignored_idx0", key_round, K2);

    // Reload mid-expansion at rnd 5
    key_in = K1; key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_busy", 128'(busy), 128'd1);
    key_in = K2; key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    wait_valid(1, n);
    chk("latency_reload", 128'(n), 128'd11);
    stream();
    chk("reload_rk0", obs[0], K2);
    chk("reload_rk10", obs[10], K2_R10);

    // Asynchronous kill between edges during expansion
    key_in = K1; key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 kill = 1'b1;
    #1;
    chk("kill_busy", 128'(busy), 128'd0);
    chk("kill_valid", 128'(key_valid), 128'd0);
    chk("kill_round", key_round, 128'd0);
    kill = 1'b0;
    @(posedge clk); #1;
    chk("post_kill_idle", 128'(busy), 128'd0);
    do_load(K2, n);
    chk("latency_after_kill", 128'(n), 128'd11);
    stream();
    chk("after_kill_rk0", obs[0], K2);
    chk("after_kill_rk10", obs[10], K2_R10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
